// File: rtl/lcmv_pipe_pkg.sv
// Shared sizing helpers and error-flag type for the latency credit FIFO.
package lcmv_pipe_pkg;

  // Bits needed to hold a count in the range 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries, never less than one.
  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  typedef struct packed {
    logic overflow;
    logic orphan;
  } err_flags_t;

endpackage

// File: rtl/credit_fifo_mem.sv
// Reset-less FIFO storage: one synchronous write port and one asynchronous read port.
module credit_fifo_mem
  import lcmv_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int PW        = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is written on the clock edge only; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/latency_credit_fifo.sv
// Credit-gated elastic output stage behind a fixed-latency, non-stallable pipeline.
// Credits reserve a FIFO slot at issue time so every returning result has room.
module latency_credit_fifo
  import lcmv_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int LATENCY    = 4,
  localparam int CW        = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         occupancy,
  output logic [CW-1:0]         credits,
  output logic                  err_overflow,
  output logic                  err_orphan
);

  localparam int PW = ptr_width(DEPTH);

  logic [CW-1:0] credits_q, credits_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  err_flags_t    err_q, err_d;

  logic issue, pop, push, full;
  logic orphan_evt, overflow_evt, write_en;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign issue        = issue_valid && (credits_q != '0);
  assign pop          = (occ_q != '0) && out_ready;
  assign push         = in_valid;
  assign full         = (occ_q == CW'(DEPTH));
  assign orphan_evt   = push && (inflight_q == '0) && !issue;
  assign overflow_evt = push && full && !pop;
  assign write_en     = push && !overflow_evt;

  // Next-state arithmetic; an orphan push does not decrement in-flight so the count cannot wrap.
  always_comb begin
    credits_d      = credits_q - CW'(issue) + CW'(pop);
    inflight_d     = inflight_q + CW'(issue) - CW'(push && !orphan_evt);
    occ_d          = occ_q + CW'(write_en) - CW'(pop);
    wr_ptr_d       = write_en ? advance(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d       = pop ? advance(rd_ptr_q) : rd_ptr_q;
    err_d.overflow = err_q.overflow | overflow_evt;
    err_d.orphan   = err_q.orphan | orphan_evt;
  end

  // Control registers; reset discards everything stored or in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q  <= CW'(DEPTH);
      inflight_q <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      err_q      <= '0;
    end else begin
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      err_q      <= err_d;
    end
  end

  credit_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (write_en),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

  assign issue_ready  = (credits_q != '0);
  assign out_valid    = (occ_q != '0);
  assign occupancy    = occ_q;
  assign credits      = credits_q;
  assign err_overflow = err_q.overflow;
  assign err_orphan   = err_q.orphan;

  // Every slot is either a free credit, an operation in flight, or a stored entry.
  a_slot_accounting: assert property (@(posedge clk) disable iff (!rst_n)
    (!err_q.overflow && !err_q.orphan) |->
      (32'(credits_q) + 32'(inflight_q) + 32'(occ_q) == DEPTH));

  // Full throughput needs one slot per pipeline stage plus one for the output.
  a_depth_covers_latency: assert property (@(posedge clk) DEPTH >= LATENCY + 1);

endmodule

// File: tb/tb_latency_credit_fifo.sv
// Self-checking bench for latency_credit_fifo: directed scenarios plus random traffic,
// compared against a queue-based model of the credit/FIFO rules.
module tb_latency_credit_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LAT   = 4;
  localparam int CW    = 4;
  localparam int D5    = 5;
  localparam int CW5   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  logic          issue_valid, issue_ready, in_valid, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] occupancy, credits;
  logic          err_overflow, err_orphan;

  logic           d5IssueValid, d5IssueReady, d5InValid, d5OutValid, d5OutReady;
  logic [DW-1:0]  d5InData, d5OutData;
  logic [CW5-1:0] d5Occupancy, d5Credits;
  logic           d5ErrOverflow, d5ErrOrphan;

  latency_credit_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .credits(credits),
    .err_overflow(err_overflow), .err_orphan(err_orphan)
  );

  latency_credit_fifo #(.DATA_WIDTH(DW), .DEPTH(D5), .LATENCY(LAT)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(d5IssueValid), .issue_ready(d5IssueReady),
    .in_valid(d5InValid), .in_data(d5InData),
    .out_valid(d5OutValid), .out_ready(d5OutReady), .out_data(d5OutData),
    .occupancy(d5Occupancy), .credits(d5Credits),
    .err_overflow(d5ErrOverflow), .err_orphan(d5ErrOrphan)
  );

  int checkCount = 0;
  int errorCount = 0;

  // Upstream fixed-latency pipeline (reset-less, like the real delay lines).
  logic          pipeV [LAT];
  logic [DW-1:0] pipeD [LAT];
  logic          lastAccepted;

  // Behavioural model of the DEPTH=8 instance.
  logic [DW-1:0] mQ [$];
  int            mCredits;
  int            mInflight;
  logic          mErrOv, mErrOr;

  // Behavioural model of the DEPTH=5 instance.
  logic [DW-1:0] m5Q [$];
  int            m5Credits;
  int            d5Pushes, d5Pops;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Compare every observable output of the main instance against the model.
  task automatic checkAll();
    checkOutput("occupancy", 32'(occupancy), 32'(mQ.size()));
    checkOutput("credits", 32'(credits), 32'(mCredits));
    checkOutput("out_valid", 32'(out_valid), 32'(mQ.size() != 0));
    checkOutput("issue_ready", 32'(issue_ready), 32'(mCredits != 0));
    checkOutput("err_overflow", 32'(err_overflow), 32'(mErrOv));
    checkOutput("err_orphan", 32'(err_orphan), 32'(mErrOr));
    if (mQ.size() != 0) checkOutput("out_data", out_data, mQ[0]);
  endtask

  task automatic resetModel();
    mQ.delete();
    mCredits  = DEPTH;
    mInflight = 0;
    mErrOv    = 1'b0;
    mErrOr    = 1'b0;
    m5Q.delete();
    m5Credits = D5;
  endtask

  // Synchronous-looking reset pulse spanning two edges; optionally flush the upstream pipe.
  task automatic resetDut(input bit flushPipe);
    rst_n = 1'b0;
    issue_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    d5IssueValid = 1'b0; d5InValid = 1'b0; d5OutReady = 1'b0; d5InData = '0;
    resetModel();
    if (flushPipe) begin
      for (int i = 0; i < LAT; i++) begin
        pipeV[i] = 1'b0;
        pipeD[i] = '0;
      end
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of traffic on the main instance, then model update and full check.
  task automatic applyStimulus(input bit iv, input bit ordy, input bit forcePush,
                               input logic [DW-1:0] issueData, input logic [DW-1:0] forceData);
    bit            mIssue, mPop, mPush, orphan;
    logic [DW-1:0] pushData;
    issue_valid = iv;
    out_ready   = ordy;
    in_valid    = pipeV[LAT-1] || forcePush;
    in_data     = forcePush ? forceData : pipeD[LAT-1];
    lastAccepted = iv && issue_ready;
    mIssue   = iv && (mCredits > 0);
    mPop     = ordy && (mQ.size() > 0);
    mPush    = in_valid;
    pushData = in_data;
    @(posedge clk);
    orphan = mPush && (mInflight == 0) && !mIssue;
    if (orphan) mErrOr = 1'b1;
    mInflight = mInflight + int'(mIssue) - int'(mPush && !orphan);
    if (mPop) void'(mQ.pop_front());
    if (mPush) begin
      if (mQ.size() < DEPTH) mQ.push_back(pushData);
      else mErrOv = 1'b1;
    end
    mCredits = mCredits - int'(mIssue) + int'(mPop);
    for (int i = LAT - 1; i > 0; i--) begin
      pipeV[i] = pipeV[i-1];
      pipeD[i] = pipeD[i-1];
    end
    pipeV[0] = lastAccepted;
    pipeD[0] = issueData;
    #1;
    checkAll();
  endtask

  // Asynchronous reset between edges; the upstream pipe keeps its results.
  task automatic midReset();
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkAll();
    #1;
    rst_n = 1'b1;
  endtask

  // One clock on the DEPTH=5 instance: results return in the same cycle as their issue.
  task automatic applyStim5(input bit iv, input bit ordy, input logic [DW-1:0] data);
    bit mIssue, mPop, mPush;
    d5IssueValid = iv;
    d5OutReady   = ordy;
    d5InValid    = iv && d5IssueReady;
    d5InData     = data;
    mIssue = iv && (m5Credits > 0);
    mPop   = ordy && (m5Q.size() > 0);
    mPush  = d5InValid;
    @(posedge clk);
    if (mPop) begin
      void'(m5Q.pop_front());
      d5Pops++;
    end
    if (mPush && m5Q.size() < D5) begin
      m5Q.push_back(data);
      d5Pushes++;
    end
    m5Credits = m5Credits - int'(mIssue) + int'(mPop);
    #1;
    checkOutput("d5_occupancy", 32'(d5Occupancy), 32'(m5Q.size()));
    checkOutput("d5_credits", 32'(d5Credits), 32'(m5Credits));
    checkOutput("d5_out_valid", 32'(d5OutValid), 32'(m5Q.size() != 0));
    checkOutput("d5_errors", {30'd0, d5ErrOverflow, d5ErrOrphan}, 32'd0);
    if (m5Q.size() != 0) checkOutput("d5_out_data", d5OutData, m5Q[0]);
  endtask

  initial begin
    int            accepted;
    int            zeroCredit;
    logic [DW-1:0] firstData;

    resetDut(1'b1);

    // Test 1: four issues with the consumer stalled, results 0xA0..0xA3.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i < 4, 1'b0, 1'b0, 32'hA0 + 32'(i), '0);
      if (i == 3) checkOutput("t1_empty_before_push", 32'(out_valid), 32'd0);
      if (i == 4) checkOutput("t1_valid_after_push", 32'(out_valid), 32'd1);
    end
    checkOutput("t1_occupancy", 32'(occupancy), 32'd4);
    checkOutput("t1_credits", 32'(credits), 32'd4);
    checkOutput("t1_head", out_data, 32'hA0);

    // Test 2: continuous issue with stalled consumer accepts exactly DEPTH operations.
    resetDut(1'b1);
    accepted  = 0;
    firstData = 32'h2000_0000;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h2000_0000 + 32'(i), '0);
      if (lastAccepted) accepted++;
    end
    checkOutput("t2_accepted", 32'(accepted), 32'd8);
    checkOutput("t2_occupancy", 32'(occupancy), 32'd8);
    checkOutput("t2_credits", 32'(credits), 32'd0);
    checkOutput("t2_errors", {30'd0, err_overflow, err_orphan}, 32'd0);

    // Test 4: forced push while full is dropped; push with pop while full proceeds.
    applyStimulus(1'b0, 1'b0, 1'b1, '0, 32'hDEAD_BEEF);
    checkOutput("t4_overflow", 32'(err_overflow), 32'd1);
    checkOutput("t4_occupancy", 32'(occupancy), 32'd8);
    checkOutput("t4_head", out_data, firstData);
    applyStimulus(1'b0, 1'b1, 1'b1, '0, 32'h1234_5678);
    checkOutput("t4_full_pushpop", 32'(occupancy), 32'd8);

    // Test 3: sustained issue with a free-running consumer.
    resetDut(1'b1);
    accepted   = 0;
    zeroCredit = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, $urandom, '0);
      if (lastAccepted) accepted++;
      if (credits == '0) zeroCredit++;
    end
    checkOutput("t3_accepted", 32'(accepted), 32'd100);
    checkOutput("t3_zero_credit_cycles", 32'(zeroCredit), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    checkOutput("t3_drained", 32'(occupancy), 32'd0);

    // Test 5: a result with nothing issued is flagged but still stored.
    resetDut(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, 32'hFF);
    checkOutput("t5_orphan", 32'(err_orphan), 32'd1);
    checkOutput("t5_occupancy", 32'(occupancy), 32'd1);
    checkOutput("t5_head", out_data, 32'hFF);
    checkOutput("t5_no_overflow", 32'(err_overflow), 32'd0);

    // Random traffic against the model.
    resetDut(1'b1);
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0, $urandom, '0);
    end
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    checkOutput("rand_errors", {30'd0, err_overflow, err_orphan}, 32'd0);

    // Test 6: async reset with 3 stored and 2 in flight; late results become orphans.
    resetDut(1'b1);
    for (int i = 0; i < 20 && mQ.size() < 3; i++) begin
      applyStimulus(i < 5, 1'b0, 1'b0, 32'hC0 + 32'(i), '0);
    end
    checkOutput("t6_stored", 32'(occupancy), 32'd3);
    midReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("t6_orphan", 32'(err_orphan), 32'd1);
    checkOutput("t6_occupancy", 32'(occupancy), 32'd2);
    checkOutput("t6_head", out_data, 32'hC3);

    // DEPTH=5 variant: pointers must wrap cleanly over at least 12 transfers.
    resetDut(1'b1);
    d5Pushes = 0;
    d5Pops   = 0;
    for (int i = 0; i < 200 && d5Pops < 12; i++) begin
      applyStim5(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end
    checkOutput("d5_transfers", 32'(d5Pops >= 12), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
